fir_mac_sequencer: RTL
======================

Name: fir_mac_sequencer

Overview:
Time-multiplexed FIR controller. It owns one shared signed multiply-accumulate resource and an N_TAPS sample delay line. It sequences one MAC per tap per accepted sample. Coefficients are runtime-loadable over a simple write port, and results leave on a valid/ready stream. It sits between the pad-level sample input and the output pins, and replaces per-tap parallel adders when the tap count grows.

Parameters:
N_TAPS, 4, number of taps / MAC cycles per sample (>=2)
BW_IN, 2, signed input sample width
BW_COEF, 3, signed coefficient width
BW_ACC, 8, signed accumulator and output width (>= BW_IN+BW_COEF)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
cfg_we  in  1  coefficient write strobe
cfg_addr  in  $clog2(N_TAPS)  coefficient index
cfg_data  in  BW_COEF  signed coefficient value
in_valid  in  1  sample offered
in_ready  out  1  sample can be accepted
in_data  in  BW_IN  signed sample
out_valid  out  1  result available
out_ready  in  1  downstream accepts result
out_data  out  BW_ACC  signed filter output
busy  out  1  high in MAC or HOLD state

Behaviour:
- Clock is clk. Reset is reset: synchronous, active-high. Reset wins over every other input in the same cycle.
- Reset values:
  - state=IDLE, tap index=0, acc=0.
  - All delay-line entries=0. All coefficients=0.
  - in_ready=1, out_valid=0, out_data=0, busy=0.
- FSM states: IDLE, MAC, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at an edge: shift the delay line (tap[0]<=in_data, tap[k]<=tap[k-1], oldest dropped), clear acc, set idx=0, go to MAC.
- MAC:
  - in_ready=0.
  - Each edge: acc <= acc + coef[idx]*tap[idx]; idx++.
  - After the edge with idx=N_TAPS-1, go to HOLD.
  - Exactly N_TAPS MAC edges per sample.
- HOLD:
  - out_valid=1, out_data=acc. Both are held stable until out_ready=1 at an edge; then go to IDLE.
  - No new sample is accepted in HOLD. The next sample is accepted no earlier than the edge after the handshake.
- Latency: the acceptance edge is E0. out_valid is visible after edge E(N_TAPS). With out_ready tied high, throughput is 1 sample per N_TAPS+2 cycles.
- Arithmetic:
  - Products are full-precision signed, BW_IN+BW_COEF bits, then sign-extended to BW_ACC.
  - Accumulation wraps modulo 2^BW_ACC (default build).
- Config port:
  - cfg_we is honoured only in IDLE. In MAC/HOLD it is silently dropped, so coefficients never change mid-sample.
  - cfg_addr >= N_TAPS is ignored.
  - A write in the same IDLE cycle as a sample acceptance takes effect for that sample. The write lands at the same edge as the shift, before the first MAC.
- Reset mid-operation: abort immediately, with no output for the in-flight sample. Delay line and coefficients are cleared.
- out_data outside HOLD holds the last result. It is 0 after reset.

Optional Feature:
SATURATE_EN. When defined, each accumulate step saturates to [-2^(BW_ACC-1), 2^(BW_ACC-1)-1]. Later steps continue from the clamped value. When undefined, accumulation wraps as specified above. The macro has no effect on ports or timing.

Decomposition:
- Shared package fir_pkg holds:
  - state enum (IDLE, MAC, HOLD)
  - width helper constants: product width = BW_IN+BW_COEF; index width = $clog2(N_TAPS)
  - saturation min/max localparams derived from BW_ACC
- One sub-module, fir_mac_unit: combinational signed multiply, sign-extension, and add, with saturation under SATURATE_EN. The sequencer instantiates it once.

Test Plan:
- Impulse (N_TAPS=4, coefs 1,2,0,-1 written in IDLE): feed 1,0,0,0 with out_ready=1 -> outputs 1,2,0,-1, each out_valid exactly 4 cycles after acceptance.
- Step with coefs 1,2,0,-1: feed 1,1,1,1,1 -> outputs 1,3,3,2,2. Then feed -2 -> 2-3 = -1 (decimal, 8-bit 0xFF).
- Backpressure: hold out_ready=0 for 5 cycles in HOLD -> out_valid/out_data stable, in_ready=0 throughout. Release -> IDLE the next cycle, in_ready=1.
- Config during busy: cfg_we addr0 data=3 during MAC -> ignored; the next impulse still gives 1 at tap 0. The same write in IDLE -> 3.
- Reset mid-MAC (assert at MAC idx=2) -> out_valid never asserts for that sample, and all outputs return to reset values. A following impulse with freshly written coefs gives clean results with no residual history.
- Overflow (BW_ACC=5, coefs all -4, step input -2 until the line is full) -> with SATURATE_EN the result is 15; without it, 32 mod 32 = 0.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and width helpers for the time-multiplexed FIR sequencer.
// Saturating accumulation is selected with the SATURATE_EN macro.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        HOLD
    } state_t;

    localparam int N_TAPS_DEF  = 4;
    localparam int BW_IN_DEF   = 2;
    localparam int BW_COEF_DEF = 3;
    localparam int BW_ACC_DEF  = 8;

    function automatic int prod_w(input int bw_in, input int bw_coef);
        return bw_in + bw_coef;
    endfunction

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int sat_max(input int bw);
        return (1 << (bw - 1)) - 1;
    endfunction

    function automatic int sat_min(input int bw);
        return -(1 << (bw - 1));
    endfunction

    localparam int PROD_W  = prod_w(BW_IN_DEF, BW_COEF_DEF);
    localparam int IDX_W   = idx_w(N_TAPS_DEF);
    localparam int SAT_MAX = sat_max(BW_ACC_DEF);
    localparam int SAT_MIN = sat_min(BW_ACC_DEF);

endpackage

// File: rtl/fir_mac_unit.sv
// Combinational signed multiply, sign-extend and accumulate step.
// With SATURATE_EN defined the sum clamps to the accumulator range.
module fir_mac_unit
    import fir_pkg::*;
#(
    parameter int BW_IN   = 2,
    parameter int BW_COEF = 3,
    parameter int BW_ACC  = 8
) (
    input  logic signed [BW_IN-1:0]   sample,
    input  logic signed [BW_COEF-1:0] coef,
    input  logic signed [BW_ACC-1:0]  acc,
    output logic signed [BW_ACC-1:0]  sum
);

    localparam int P_W = prod_w(BW_IN, BW_COEF);

    logic signed [P_W-1:0]    prod;
    logic signed [BW_ACC-1:0] term;

    assign prod = P_W'(sample) * P_W'(coef);
    assign term = BW_ACC'(prod);

`ifdef SATURATE_EN
    localparam logic signed [BW_ACC-1:0] ACC_MAX = BW_ACC'(sat_max(BW_ACC));
    localparam logic signed [BW_ACC-1:0] ACC_MIN = BW_ACC'(sat_min(BW_ACC));

    logic signed [BW_ACC:0] wide;

    // One guard bit: overflow shows as a mismatch of the top two bits.
    assign wide = (BW_ACC + 1)'(acc) + (BW_ACC + 1)'(term);

    always_comb begin
        sum = wide[BW_ACC-1:0];
        if (wide[BW_ACC] != wide[BW_ACC-1]) begin
            sum = wide[BW_ACC] ? ACC_MIN : ACC_MAX;
        end
    end
`else
    assign sum = acc + term;
`endif

endmodule

// File: rtl/fir_mac_sequencer.sv
// FIR controller: one shared MAC stepped over N_TAPS taps per sample.
// SATURATE_EN (in fir_mac_unit) switches wrap to saturating accumulation.
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int N_TAPS  = 4,
    parameter int BW_IN   = 2,
    parameter int BW_COEF = 3,
    parameter int BW_ACC  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cfg_we,
    input  logic [$clog2(N_TAPS)-1:0]   cfg_addr,
    input  logic signed [BW_COEF-1:0]   cfg_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [BW_IN-1:0]     in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [BW_ACC-1:0]    out_data,
    output logic                        busy
);

    localparam int I_W = idx_w(N_TAPS);

    state_t                   state;
    logic [I_W-1:0]           idx;
    logic signed [BW_ACC-1:0] acc;
    logic signed [BW_ACC-1:0] mac_sum;
    logic signed [BW_IN-1:0]  taps  [N_TAPS];
    logic signed [BW_COEF-1:0] coefs [N_TAPS];
    logic                     last;
    logic                     cfg_hit;

    assign last    = (idx == I_W'(N_TAPS - 1));
    assign cfg_hit = cfg_we && (int'(cfg_addr) < N_TAPS);

    fir_mac_unit #(
        .BW_IN  (BW_IN),
        .BW_COEF(BW_COEF),
        .BW_ACC (BW_ACC)
    ) u_mac (
        .sample(taps[idx]),
        .coef  (coefs[idx]),
        .acc   (acc),
        .sum   (mac_sum)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            acc       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            for (int k = 0; k < N_TAPS; k++) begin
                taps[k]  <= '0;
                coefs[k] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    // Coefficients only change here, never mid-sample.
                    if (cfg_hit) begin
                        coefs[cfg_addr] <= cfg_data;
                    end
                    if (in_valid && in_ready) begin
                        taps[0] <= in_data;
                        for (int k = 1; k < N_TAPS; k++) begin
                            taps[k] <= taps[k-1];
                        end
                        acc      <= '0;
                        idx      <= '0;
                        state    <= MAC;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                MAC: begin
                    acc <= mac_sum;
                    idx <= idx + I_W'(1);
                    if (last) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        out_data  <= mac_sum;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
